id_stage: RTL and testbench
===========================

Name: id_stage

Overview:
- Registered decode stage of the 5-stage MIPS32 subset core.
- Holds the IF/ID pipeline register and decodes the held instruction.
- Drives the regfile read ports and resolves operands by forwarding from EX and MEM, then presents a registered ID/EX bundle to the execute stage.
- Detects load-use hazards and requests a stall.

Parameters:
- RESET_PC, 32'h0000_0000, value loaded into the IF/ID pc field on reset and flush.

Ports:
- clk  in  1  core clock; all state updates on its rising edge
- rst  in  1  synchronous, active-high reset
- if_valid_i  in  1  fetch presents a valid instruction
- if_pc_i  in  32  pc of the fetched instruction
- if_inst_i  in  32  fetched instruction
- stall_i  in  1  global stall from ctrl; freezes both pipeline registers
- flush_i  in  1  kill everything held in this stage
- reg1_read_o  out  1  regfile read enable, port 1
- reg1_addr_o  out  5  regfile read address, port 1
- reg1_data_i  in  32  regfile read data, port 1 (combinational, includes WB write-through)
- reg2_read_o  out  1  regfile read enable, port 2
- reg2_addr_o  out  5  regfile read address, port 2
- reg2_data_i  in  32  regfile read data, port 2
- ex_wreg_i  in  1  EX stage writes a register
- ex_wd_i  in  5  EX destination register
- ex_wdata_i  in  32  EX result
- ex_is_load_i  in  1  EX instruction is LW
- mem_wreg_i  in  1  MEM stage writes a register
- mem_wd_i  in  5  MEM destination register
- mem_wdata_i  in  32  MEM result
- stallreq_o  out  1  load-use stall request (combinational)
- ex_valid_o  out  1  ID/EX slot holds a real instruction
- ex_pc_o  out  32  pc of that instruction
- ex_aluop_o  out  4  ALU operation (encoding in package)
- ex_reg1_o  out  32  operand A
- ex_reg2_o  out  32  operand B
- ex_sdata_o  out  32  store data (SW only, else 0)
- ex_wd_o  out  5  destination register
- ex_wreg_o  out  1  destination write enable
- ex_mem_re_o  out  1  load
- ex_mem_we_o  out  1  store

Behaviour:
- Reset: IF/ID is valid=0, pc=RESET_PC, inst=0. All ex_* outputs are 0. This holds from the first edge with rst=1.
- Latency: an instruction accepted at edge n appears on ex_* after edge n+1.
- Edge priority: rst > flush_i > stall_i > stallreq_o > advance.
  - flush_i: IF/ID and ID/EX both load bubbles (all zero, IF/ID pc=RESET_PC).
  - stall_i: both registers hold.
  - stallreq_o with stall_i=0: IF/ID holds and ID/EX loads a bubble.
  - Advance: IF/ID loads if_*; ID/EX loads the decoded bundle with ex_valid_o equal to the IF/ID valid bit.
- Invalid IF/ID entry: decodes as a bubble. No reads, no writes, no stall request.
- Decode subset (op/funct):
  - SPECIAL with funct ADDU 100001, SUBU 100011, AND 100100, OR 100101, XOR 100110, NOR 100111, SLT 101010: read rs and rt, write rd.
  - SPECIAL SLL 000000 / SRL 000010: read rt only. reg1 = zero-extended shamt, reg2 = rt.
  - ORI 001101, ANDI 001100, XORI 001110: reg2 = zero-extended imm. ADDIU 001001: reg2 = sign-extended imm. All read rs and write rt.
  - LUI 001111: no reads. reg1 = {imm,16'h0}, reg2 = 0, aluop OR, write rt.
  - LW 100011: reg1 = rs, reg2 = sign-extended imm, aluop ADD, mem_re=1, write rt.
  - SW 101011: reads rs and rt. reg1 = rs, reg2 = sign-extended imm, sdata = rt, aluop ADD, mem_we=1, wreg=0.
  - Any other encoding: aluop NOP, no reads, wreg=0, valid passes through unchanged.
- Read enables and addresses: reg*_read_o/addr_o are driven from IF/ID every cycle, including during a stall. An unused port has read=0, addr=0.
- Operand resolution per port, applied only when the port's read enable is 1. Priority:
  1. addr==0 gives 0.
  2. ex_wreg_i and ex_wd_i==addr gives ex_wdata_i.
  3. mem_wreg_i and mem_wd_i==addr gives mem_wdata_i.
  4. Otherwise the regfile data.
- stallreq_o = 1 when all of the following hold:
  - IF/ID is valid and flush_i=0;
  - ex_is_load_i and ex_wreg_i are set;
  - ex_wd_i != 0;
  - ex_wd_i matches an address whose read enable is 1.
- Simultaneous stall_i and stallreq_o: stall_i wins and nothing moves. stallreq_o stays asserted.

Decomposition:
- Package id_pkg:
  - opcode/funct constants;
  - 4-bit aluop encoding: NOP 0, ADD 1, SUB 2, AND 3, OR 4, XOR 5, NOR 6, SLL 7, SRL 8, SLT 9;
  - bubble bundle constant;
  - ID/EX bundle field widths.
- One sub-module, id_decode: purely combinational. Maps inst to read enables, addresses, immediates, aluop, wd, wreg and mem flags.
- Forwarding, hazard detection and both registers stay in id_stage.

Test Plan:
- Reset with rst=1 for 2 edges, if_valid_i=1 → all ex_* are 0 and stallreq_o=0.
- ORI $1,$0,0x1234 (inst 34011234) → two edges later: ex_reg1_o=0, ex_reg2_o=0x00001234, ex_wd_o=1, ex_wreg_o=1, aluop OR.
- ADDU $3,$1,$2 with ex_wd_i=1 (wdata 5) and mem_wd_i=2 (wdata 7), regfile returning 0xFF → ex_reg1_o=5, ex_reg2_o=7. Repeat with ex_wd_i=mem_wd_i=1 (5 vs 9) → EX value 5 wins.
- LW in EX (ex_is_load_i=1, ex_wd_i=4) while IF/ID holds ADDU $5,$4,$0:
  - stallreq_o=1 for that cycle;
  - ex_valid_o=0 after the edge;
  - the ADDU is presented on the next cycle once ex_is_load_i drops.
- stall_i=1 for 3 cycles mid-stream → ex_* and the IF/ID contents are unchanged. flush_i=1 with stall_i=1 → bubbles on the next edge.
- SW $7,-4($6) (inst ACC7FFFC) with $7 forwarded from MEM = 0xDEADBEEF → ex_reg2_o=0xFFFFFFFC, ex_sdata_o=0xDEADBEEF, ex_mem_we_o=1, ex_wreg_o=0.

Source files
------------

// File: rtl/id_pkg.sv
// Shared decode-stage types and constants for the MIPS32 subset core.
// Opcode/funct values, ALU op encoding and the IF/ID and ID/EX bundles.
package id_pkg;

  localparam int XLEN    = 32;
  localparam int REG_AW  = 5;
  localparam int ALUOP_W = 4;

  localparam logic [5:0] OP_SPECIAL = 6'b000000;
  localparam logic [5:0] OP_ADDIU   = 6'b001001;
  localparam logic [5:0] OP_ANDI    = 6'b001100;
  localparam logic [5:0] OP_ORI     = 6'b001101;
  localparam logic [5:0] OP_XORI    = 6'b001110;
  localparam logic [5:0] OP_LUI     = 6'b001111;
  localparam logic [5:0] OP_LW      = 6'b100011;
  localparam logic [5:0] OP_SW      = 6'b101011;

  localparam logic [5:0] FN_SLL  = 6'b000000;
  localparam logic [5:0] FN_SRL  = 6'b000010;
  localparam logic [5:0] FN_ADDU = 6'b100001;
  localparam logic [5:0] FN_SUBU = 6'b100011;
  localparam logic [5:0] FN_AND  = 6'b100100;
  localparam logic [5:0] FN_OR   = 6'b100101;
  localparam logic [5:0] FN_XOR  = 6'b100110;
  localparam logic [5:0] FN_NOR  = 6'b100111;
  localparam logic [5:0] FN_SLT  = 6'b101010;

  typedef enum logic [ALUOP_W-1:0] {
    ALU_NOP = 4'd0,
    ALU_ADD = 4'd1,
    ALU_SUB = 4'd2,
    ALU_AND = 4'd3,
    ALU_OR  = 4'd4,
    ALU_XOR = 4'd5,
    ALU_NOR = 4'd6,
    ALU_SLL = 4'd7,
    ALU_SRL = 4'd8,
    ALU_SLT = 4'd9
  } aluop_e;

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inst;
  } if_id_t;

  typedef struct packed {
    logic              valid;
    logic [XLEN-1:0]   pc;
    aluop_e            aluop;
    logic [XLEN-1:0]   reg1;
    logic [XLEN-1:0]   reg2;
    logic [XLEN-1:0]   sdata;
    logic [REG_AW-1:0] wd;
    logic              wreg;
    logic              mem_re;
    logic              mem_we;
  } id_ex_t;

  localparam id_ex_t ID_EX_BUBBLE = '0;

  typedef struct packed {
    logic              re1;
    logic [REG_AW-1:0] a1;
    logic              re2;
    logic [REG_AW-1:0] a2;
    logic              use2;
    logic              st;
    logic [XLEN-1:0]   imm1;
    logic [XLEN-1:0]   imm2;
    aluop_e            aluop;
    logic [REG_AW-1:0] wd;
    logic              wreg;
    logic              mem_re;
    logic              mem_we;
  } dec_t;

  function automatic aluop_e r_aluop(input logic [5:0] fn);
    case (fn)
      FN_ADDU: return ALU_ADD;
      FN_SUBU: return ALU_SUB;
      FN_AND:  return ALU_AND;
      FN_OR:   return ALU_OR;
      FN_XOR:  return ALU_XOR;
      FN_NOR:  return ALU_NOR;
      FN_SLT:  return ALU_SLT;
      default: return ALU_NOP;
    endcase
  endfunction

  function automatic aluop_e i_aluop(input logic [5:0] op);
    case (op)
      OP_ADDIU: return ALU_ADD;
      OP_ANDI:  return ALU_AND;
      OP_ORI:   return ALU_OR;
      OP_XORI:  return ALU_XOR;
      default:  return ALU_NOP;
    endcase
  endfunction

  // Youngest producer wins; $0 is never forwarded.
  function automatic logic [XLEN-1:0] fwd(
    input logic [REG_AW-1:0] a,
    input logic [XLEN-1:0]   rf,
    input logic              ew,
    input logic [REG_AW-1:0] ed,
    input logic [XLEN-1:0]   ev,
    input logic              mw,
    input logic [REG_AW-1:0] md,
    input logic [XLEN-1:0]   mv
  );
    if (a == '0) return '0;
    if (ew && ed == a) return ev;
    if (mw && md == a) return mv;
    return rf;
  endfunction

endpackage

// File: rtl/id_decode.sv
// Combinational instruction decoder for the ID stage.
// Invalid or unknown encodings decode to an all-zero bundle.
module id_decode
  import id_pkg::*;
(
  input  logic        valid,
  input  logic [31:0] inst,
  output dec_t        dec
);

  logic [5:0]  op;
  logic [5:0]  fn;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [4:0]  sa;
  logic [31:0] sext;
  logic [31:0] zext;
  logic        is_r;
  logic        is_sh;
  logic        is_imm;
  logic        is_lui;
  logic        is_lw;
  logic        is_sw;
  logic        spec;

  assign op   = inst[31:26];
  assign rs   = inst[25:21];
  assign rt   = inst[20:16];
  assign rd   = inst[15:11];
  assign sa   = inst[10:6];
  assign fn   = inst[5:0];
  assign sext = {{16{inst[15]}}, inst[15:0]};
  assign zext = {16'h0, inst[15:0]};
  assign spec = valid && op == OP_SPECIAL;

  assign is_r   = spec && r_aluop(fn) != ALU_NOP;
  assign is_sh  = spec && (fn == FN_SLL || fn == FN_SRL);
  assign is_imm = valid && i_aluop(op) != ALU_NOP;
  assign is_lui = valid && op == OP_LUI;
  assign is_lw  = valid && op == OP_LW;
  assign is_sw  = valid && op == OP_SW;

  always_comb begin
    dec = '0;
    unique case (1'b1)
      is_r: begin
        dec.re1   = 1'b1;
        dec.a1    = rs;
        dec.re2   = 1'b1;
        dec.a2    = rt;
        dec.use2  = 1'b1;
        dec.aluop = r_aluop(fn);
        dec.wd    = rd;
        dec.wreg  = 1'b1;
      end
      is_sh: begin
        dec.re2   = 1'b1;
        dec.a2    = rt;
        dec.use2  = 1'b1;
        dec.imm1  = {27'h0, sa};
        dec.aluop = (fn == FN_SLL) ? ALU_SLL : ALU_SRL;
        dec.wd    = rd;
        dec.wreg  = 1'b1;
      end
      is_imm: begin
        dec.re1   = 1'b1;
        dec.a1    = rs;
        dec.imm2  = (op == OP_ADDIU) ? sext : zext;
        dec.aluop = i_aluop(op);
        dec.wd    = rt;
        dec.wreg  = 1'b1;
      end
      is_lui: begin
        dec.imm1  = {inst[15:0], 16'h0};
        dec.aluop = ALU_OR;
        dec.wd    = rt;
        dec.wreg  = 1'b1;
      end
      is_lw: begin
        dec.re1    = 1'b1;
        dec.a1     = rs;
        dec.imm2   = sext;
        dec.aluop  = ALU_ADD;
        dec.wd     = rt;
        dec.wreg   = 1'b1;
        dec.mem_re = 1'b1;
      end
      is_sw: begin
        dec.re1    = 1'b1;
        dec.a1     = rs;
        dec.re2    = 1'b1;
        dec.a2     = rt;
        dec.st     = 1'b1;
        dec.imm2   = sext;
        dec.aluop  = ALU_ADD;
        dec.mem_we = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/id_stage.sv
// Registered decode stage: IF/ID register, operand forwarding,
// load-use stall request and the ID/EX register.
module id_stage
  import id_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_valid_i,
  input  logic [31:0] if_pc_i,
  input  logic [31:0] if_inst_i,
  input  logic        stall_i,
  input  logic        flush_i,
  output logic        reg1_read_o,
  output logic [4:0]  reg1_addr_o,
  input  logic [31:0] reg1_data_i,
  output logic        reg2_read_o,
  output logic [4:0]  reg2_addr_o,
  input  logic [31:0] reg2_data_i,
  input  logic        ex_wreg_i,
  input  logic [4:0]  ex_wd_i,
  input  logic [31:0] ex_wdata_i,
  input  logic        ex_is_load_i,
  input  logic        mem_wreg_i,
  input  logic [4:0]  mem_wd_i,
  input  logic [31:0] mem_wdata_i,
  output logic        stallreq_o,
  output logic        ex_valid_o,
  output logic [31:0] ex_pc_o,
  output logic [3:0]  ex_aluop_o,
  output logic [31:0] ex_reg1_o,
  output logic [31:0] ex_reg2_o,
  output logic [31:0] ex_sdata_o,
  output logic [4:0]  ex_wd_o,
  output logic        ex_wreg_o,
  output logic        ex_mem_re_o,
  output logic        ex_mem_we_o
);

  localparam if_id_t IF_ID_RST = '{
    valid: 1'b0, pc: RESET_PC, inst: 32'h0
  };

  if_id_t      ifid;
  id_ex_t      idex;
  id_ex_t      nxt;
  dec_t        dec;
  logic [31:0] opa;
  logic [31:0] opb;
  logic        hit1;
  logic        hit2;

  id_decode u_decode (
    .valid (ifid.valid),
    .inst  (ifid.inst),
    .dec   (dec)
  );

  assign reg1_read_o = dec.re1;
  assign reg1_addr_o = dec.a1;
  assign reg2_read_o = dec.re2;
  assign reg2_addr_o = dec.a2;

  assign opa = fwd(dec.a1, reg1_data_i,
                   ex_wreg_i, ex_wd_i, ex_wdata_i,
                   mem_wreg_i, mem_wd_i, mem_wdata_i);
  assign opb = fwd(dec.a2, reg2_data_i,
                   ex_wreg_i, ex_wd_i, ex_wdata_i,
                   mem_wreg_i, mem_wd_i, mem_wdata_i);

  assign hit1 = dec.re1 && dec.a1 == ex_wd_i;
  assign hit2 = dec.re2 && dec.a2 == ex_wd_i;

  assign stallreq_o = ifid.valid && !flush_i
                   && ex_is_load_i && ex_wreg_i
                   && ex_wd_i != '0 && (hit1 || hit2);

  always_comb begin
    nxt        = ID_EX_BUBBLE;
    nxt.valid  = ifid.valid;
    nxt.pc     = ifid.valid ? ifid.pc : '0;
    nxt.aluop  = dec.aluop;
    nxt.reg1   = dec.re1 ? opa : dec.imm1;
    nxt.reg2   = dec.use2 ? opb : dec.imm2;
    nxt.sdata  = dec.st ? opb : '0;
    nxt.wd     = dec.wd;
    nxt.wreg   = dec.wreg;
    nxt.mem_re = dec.mem_re;
    nxt.mem_we = dec.mem_we;
  end

  always_ff @(posedge clk) begin
    if (rst || flush_i) begin
      ifid <= IF_ID_RST;
      idex <= ID_EX_BUBBLE;
    end else if (stall_i) begin
      ifid <= ifid;
      idex <= idex;
    end else if (stallreq_o) begin
      idex <= ID_EX_BUBBLE;
    end else begin
      ifid <= '{valid: if_valid_i, pc: if_pc_i, inst: if_inst_i};
      idex <= nxt;
    end
  end

  assign ex_valid_o  = idex.valid;
  assign ex_pc_o     = idex.pc;
  assign ex_aluop_o  = idex.aluop;
  assign ex_reg1_o   = idex.reg1;
  assign ex_reg2_o   = idex.reg2;
  assign ex_sdata_o  = idex.sdata;
  assign ex_wd_o     = idex.wd;
  assign ex_wreg_o   = idex.wreg;
  assign ex_mem_re_o = idex.mem_re;
  assign ex_mem_we_o = idex.mem_we;

endmodule

// File: tb/tb_id_stage.sv
// Self-checking bench for id_stage: directed cases plus random
// traffic compared against a behavioural model of the stage.
module tb_id_stage;

  localparam logic [31:0] RPC = 32'h0000_0000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, if_valid_i, stall_i, flush_i;
  logic [31:0] if_pc_i, if_inst_i;
  logic        reg1_read_o, reg2_read_o;
  logic [4:0]  reg1_addr_o, reg2_addr_o;
  logic [31:0] reg1_data_i, reg2_data_i;
  logic        ex_wreg_i, ex_is_load_i, mem_wreg_i;
  logic [4:0]  ex_wd_i, mem_wd_i;
  logic [31:0] ex_wdata_i, mem_wdata_i;
  logic        stallreq_o, ex_valid_o;
  logic [31:0] ex_pc_o, ex_reg1_o, ex_reg2_o, ex_sdata_o;
  logic [3:0]  ex_aluop_o;
  logic [4:0]  ex_wd_o;
  logic        ex_wreg_o, ex_mem_re_o, ex_mem_we_o;

  logic [31:0] rf [32];
  assign reg1_data_i = rf[reg1_addr_o];
  assign reg2_data_i = rf[reg2_addr_o];

  id_stage #(.RESET_PC(RPC)) dut (
    .clk(clk), .rst(rst),
    .if_valid_i(if_valid_i), .if_pc_i(if_pc_i),
    .if_inst_i(if_inst_i),
    .stall_i(stall_i), .flush_i(flush_i),
    .reg1_read_o(reg1_read_o), .reg1_addr_o(reg1_addr_o),
    .reg1_data_i(reg1_data_i),
    .reg2_read_o(reg2_read_o), .reg2_addr_o(reg2_addr_o),
    .reg2_data_i(reg2_data_i),
    .ex_wreg_i(ex_wreg_i), .ex_wd_i(ex_wd_i),
    .ex_wdata_i(ex_wdata_i), .ex_is_load_i(ex_is_load_i),
    .mem_wreg_i(mem_wreg_i), .mem_wd_i(mem_wd_i),
    .mem_wdata_i(mem_wdata_i),
    .stallreq_o(stallreq_o), .ex_valid_o(ex_valid_o),
    .ex_pc_o(ex_pc_o), .ex_aluop_o(ex_aluop_o),
    .ex_reg1_o(ex_reg1_o), .ex_reg2_o(ex_reg2_o),
    .ex_sdata_o(ex_sdata_o), .ex_wd_o(ex_wd_o),
    .ex_wreg_o(ex_wreg_o), .ex_mem_re_o(ex_mem_re_o),
    .ex_mem_we_o(ex_mem_we_o)
  );

  typedef struct packed {
    logic        r1;
    logic [4:0]  a1;
    logic        r2;
    logic [4:0]  a2;
    logic        valid;
    logic [31:0] pc;
    logic [3:0]  alu;
    logic [31:0] reg1;
    logic [31:0] reg2;
    logic [31:0] sdata;
    logic [4:0]  wd;
    logic        wreg;
    logic        mre;
    logic        mwe;
  } exp_t;

  int   checks = 0;
  int   errors = 0;
  logic known  = 1'b0;
  logic sr_seen;

  logic        mv    = 1'b0;
  logic [31:0] mpc   = '0;
  logic [31:0] minst = '0;
  exp_t        mex   = '0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] opv(input logic [4:0] a);
    if (a == 5'd0) return 32'h0;
    if (ex_wreg_i && ex_wd_i == a) return ex_wdata_i;
    if (mem_wreg_i && mem_wd_i == a) return mem_wdata_i;
    return rf[a];
  endfunction

  // What the ID/EX slot must hold for a given IF/ID entry.
  function automatic exp_t model_dec(input logic v,
      input logic [31:0] pc, input logic [31:0] in);
    exp_t e;
    logic [5:0] op, fn;
    logic [4:0] rs, rt, rd;
    logic [31:0] sx, zx;
    e  = '0;
    op = in[31:26]; fn = in[5:0];
    rs = in[25:21]; rt = in[20:16]; rd = in[15:11];
    sx = {{16{in[15]}}, in[15:0]};
    zx = {16'h0, in[15:0]};
    if (!v) return e;
    e.valid = 1'b1;
    e.pc    = pc;
    if (op == 6'h00) begin
      case (fn)
        6'h21, 6'h23, 6'h24, 6'h25,
        6'h26, 6'h27, 6'h2a: begin
          case (fn)
            6'h21: e.alu = 4'd1;
            6'h23: e.alu = 4'd2;
            6'h24: e.alu = 4'd3;
            6'h25: e.alu = 4'd4;
            6'h26: e.alu = 4'd5;
            6'h27: e.alu = 4'd6;
            default: e.alu = 4'd9;
          endcase
          e.r1 = 1; e.a1 = rs; e.r2 = 1; e.a2 = rt;
          e.reg1 = opv(rs); e.reg2 = opv(rt);
          e.wd = rd; e.wreg = 1;
        end
        6'h00, 6'h02: begin
          e.alu = (fn == 6'h00) ? 4'd7 : 4'd8;
          e.r2 = 1; e.a2 = rt;
          e.reg1 = {27'h0, in[10:6]};
          e.reg2 = opv(rt);
          e.wd = rd; e.wreg = 1;
        end
        default: ;
      endcase
    end else begin
      case (op)
        6'h0d, 6'h0c, 6'h0e, 6'h09: begin
          case (op)
            6'h0d: e.alu = 4'd4;
            6'h0c: e.alu = 4'd3;
            6'h0e: e.alu = 4'd5;
            default: e.alu = 4'd1;
          endcase
          e.r1 = 1; e.a1 = rs;
          e.reg1 = opv(rs);
          e.reg2 = (op == 6'h09) ? sx : zx;
          e.wd = rt; e.wreg = 1;
        end
        6'h0f: begin
          e.alu = 4'd4;
          e.reg1 = {in[15:0], 16'h0};
          e.wd = rt; e.wreg = 1;
        end
        6'h23: begin
          e.alu = 4'd1;
          e.r1 = 1; e.a1 = rs;
          e.reg1 = opv(rs); e.reg2 = sx;
          e.wd = rt; e.wreg = 1; e.mre = 1;
        end
        6'h2b: begin
          e.alu = 4'd1;
          e.r1 = 1; e.a1 = rs; e.r2 = 1; e.a2 = rt;
          e.reg1 = opv(rs); e.reg2 = sx;
          e.sdata = opv(rt); e.mwe = 1;
        end
        default: ;
      endcase
    end
    return e;
  endfunction

  // One clock: check combinational outputs, advance model, check ID/EX.
  task automatic step();
    exp_t d;
    logic sr;
    #1;
    d  = model_dec(mv, mpc, minst);
    sr = mv && !flush_i && ex_is_load_i && ex_wreg_i
      && ex_wd_i != 5'd0
      && ((d.r1 && d.a1 == ex_wd_i) || (d.r2 && d.a2 == ex_wd_i));
    sr_seen = stallreq_o;
    if (known) begin
      chk("stallreq", 32'(stallreq_o), 32'(sr));
      chk("rd1_en", 32'(reg1_read_o), 32'(d.r1));
      chk("rd1_addr", 32'(reg1_addr_o), 32'(d.a1));
      chk("rd2_en", 32'(reg2_read_o), 32'(d.r2));
      chk("rd2_addr", 32'(reg2_addr_o), 32'(d.a2));
    end
    if (rst || flush_i) begin
      mv = 1'b0; mpc = RPC; minst = '0; mex = '0;
    end else if (stall_i) begin
      mex = mex;
    end else if (sr) begin
      mex = '0;
    end else begin
      mex = d;
      mv = if_valid_i; mpc = if_pc_i; minst = if_inst_i;
    end
    @(posedge clk);
    #1;
    known = 1'b1;
    chk("ex_valid", 32'(ex_valid_o), 32'(mex.valid));
    chk("ex_pc", ex_pc_o, mex.pc);
    chk("ex_aluop", 32'(ex_aluop_o), 32'(mex.alu));
    chk("ex_reg1", ex_reg1_o, mex.reg1);
    chk("ex_reg2", ex_reg2_o, mex.reg2);
    chk("ex_sdata", ex_sdata_o, mex.sdata);
    chk("ex_wd", 32'(ex_wd_o), 32'(mex.wd));
    chk("ex_wreg", 32'(ex_wreg_o), 32'(mex.wreg));
    chk("ex_mem_re", 32'(ex_mem_re_o), 32'(mex.mre));
    chk("ex_mem_we", 32'(ex_mem_we_o), 32'(mex.mwe));
    @(negedge clk);
  endtask

  task automatic idle();
    rst = 0; if_valid_i = 0; if_pc_i = '0; if_inst_i = '0;
    stall_i = 0; flush_i = 0;
    ex_wreg_i = 0; ex_wd_i = '0; ex_wdata_i = '0;
    ex_is_load_i = 0;
    mem_wreg_i = 0; mem_wd_i = '0; mem_wdata_i = '0;
  endtask

  function automatic logic [31:0] rand_inst();
    logic [4:0] rs, rt, rd;
    logic [5:0] f;
    logic [15:0] imm;
    rs  = 5'($urandom_range(0, 7));
    rt  = 5'($urandom_range(0, 7));
    rd  = 5'($urandom_range(0, 7));
    imm = 16'($urandom);
    case ($urandom_range(0, 7))
      0: begin
        case ($urandom_range(0, 6))
          0: f = 6'h21; 1: f = 6'h23; 2: f = 6'h24;
          3: f = 6'h25; 4: f = 6'h26; 5: f = 6'h27;
          default: f = 6'h2a;
        endcase
        return {6'h00, rs, rt, rd, 5'h00, f};
      end
      1: begin
        f = $urandom_range(0, 1) == 0 ? 6'h00 : 6'h02;
        return {6'h00, rs, rt, rd, 5'($urandom), f};
      end
      2: begin
        case ($urandom_range(0, 3))
          0: f = 6'h0d; 1: f = 6'h0c; 2: f = 6'h0e;
          default: f = 6'h09;
        endcase
        return {f, rs, rt, imm};
      end
      3: return {6'h0f, rs, rt, imm};
      4: return {6'h23, rs, rt, imm};
      5: return {6'h2b, rs, rt, imm};
      6: return {6'h00, rs, rt, rd, 5'h00, 6'($urandom)};
      default: return $urandom;
    endcase
  endfunction

  initial begin
    for (int i = 0; i < 32; i++) rf[i] = $urandom;
    idle();
    rst = 1; if_valid_i = 1; if_inst_i = 32'h3401_1234;
    @(negedge clk);
    step();
    step();
    chk("rst_valid", 32'(ex_valid_o), 32'h0);
    chk("rst_wreg", 32'(ex_wreg_o), 32'h0);
    chk("rst_reg2", ex_reg2_o, 32'h0);
    chk("rst_stallreq", 32'(sr_seen), 32'h0);

    // ORI $1,$0,0x1234
    idle();
    if_valid_i = 1; if_pc_i = 32'h100; if_inst_i = 32'h3401_1234;
    step();
    if_valid_i = 0;
    step();
    chk("ori_reg1", ex_reg1_o, 32'h0);
    chk("ori_reg2", ex_reg2_o, 32'h1234);
    chk("ori_wd", 32'(ex_wd_o), 32'd1);
    chk("ori_wreg", 32'(ex_wreg_o), 32'd1);
    chk("ori_aluop", 32'(ex_aluop_o), 32'd4);

    // ADDU $3,$1,$2 with EX/MEM forwarding
    rf[1] = 32'hFF; rf[2] = 32'hFF;
    if_valid_i = 1; if_pc_i = 32'h104; if_inst_i = 32'h0022_1821;
    step();
    ex_wreg_i = 1; ex_wd_i = 5'd1; ex_wdata_i = 32'd5;
    mem_wreg_i = 1; mem_wd_i = 5'd2; mem_wdata_i = 32'd7;
    if_pc_i = 32'h108;
    step();
    chk("fwd_ex_a", ex_reg1_o, 32'd5);
    chk("fwd_mem_b", ex_reg2_o, 32'd7);
    mem_wd_i = 5'd1; mem_wdata_i = 32'd9; if_valid_i = 0;
    step();
    chk("fwd_prio_a", ex_reg1_o, 32'd5);
    chk("fwd_prio_b", ex_reg2_o, 32'hFF);

    // load-use: LW $4 in EX, ADDU $5,$4,$0 in ID
    idle();
    if_valid_i = 1; if_pc_i = 32'h200; if_inst_i = 32'h0080_2821;
    step();
    ex_is_load_i = 1; ex_wreg_i = 1; ex_wd_i = 5'd4;
    ex_wdata_i = 32'h44;
    if_pc_i = 32'h204; if_inst_i = 32'h3401_1234;
    step();
    chk("lu_stallreq", 32'(sr_seen), 32'd1);
    chk("lu_bubble", 32'(ex_valid_o), 32'd0);
    ex_is_load_i = 0; ex_wreg_i = 0;
    mem_wreg_i = 1; mem_wd_i = 5'd4; mem_wdata_i = 32'h44;
    step();
    chk("lu_valid", 32'(ex_valid_o), 32'd1);
    chk("lu_pc", ex_pc_o, 32'h200);
    chk("lu_reg1", ex_reg1_o, 32'h44);

    // external stall for three cycles, then flush under stall
    idle();
    if_valid_i = 1; if_pc_i = 32'h300; if_inst_i = 32'h3402_1111;
    step();
    if_pc_i = 32'h304; if_inst_i = 32'h0080_2821;
    step();
    stall_i = 1;
    for (int i = 0; i < 3; i++) begin
      if_pc_i = $urandom; if_inst_i = rand_inst();
      step();
      chk("stall_pc", ex_pc_o, 32'h300);
      chk("stall_ifid", 32'(reg1_addr_o), 32'd4);
    end
    flush_i = 1;
    step();
    chk("flush_valid", 32'(ex_valid_o), 32'd0);
    chk("flush_ifid", 32'(reg1_read_o), 32'd0);

    // SW $7,-4($6) with $7 from MEM
    idle();
    if_valid_i = 1; if_pc_i = 32'h400; if_inst_i = 32'hACC7_FFFC;
    step();
    mem_wreg_i = 1; mem_wd_i = 5'd7; mem_wdata_i = 32'hDEAD_BEEF;
    if_valid_i = 0;
    step();
    chk("sw_reg2", ex_reg2_o, 32'hFFFF_FFFC);
    chk("sw_sdata", ex_sdata_o, 32'hDEAD_BEEF);
    chk("sw_we", 32'(ex_mem_we_o), 32'd1);
    chk("sw_wreg", 32'(ex_wreg_o), 32'd0);

    // random traffic
    for (int n = 0; n < 3000; n++) begin
      rst          = $urandom_range(0, 99) == 0;
      flush_i      = $urandom_range(0, 24) == 0;
      stall_i      = $urandom_range(0, 9) == 0;
      if_valid_i   = $urandom_range(0, 4) != 0;
      if_pc_i      = $urandom & 32'hFFFF_FFFC;
      if_inst_i    = rand_inst();
      ex_wreg_i    = $urandom_range(0, 1) == 1;
      ex_wd_i      = 5'($urandom_range(0, 7));
      ex_wdata_i   = $urandom;
      ex_is_load_i = $urandom_range(0, 2) == 0;
      mem_wreg_i   = $urandom_range(0, 1) == 1;
      mem_wd_i     = 5'($urandom_range(0, 7));
      mem_wdata_i  = $urandom;
      rf[$urandom_range(0, 31)] = $urandom;
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
